// File: rtl/scan_7seg_mux.sv
// Time-multiplexed hex driver for N common-segment 7-segment digits.
// Codes are double-buffered and swapped in only when the scan wraps to digit 0.
module scan_7seg_mux #(
    parameter int N_DIGITS   = 4,
    parameter int DIV        = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] codes,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   dig,
    output logic                  frame_done
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pcodes_q, pcodes_d, dcodes_q, dcodes_d;
    logic [N_DIGITS-1:0]   pblank_q, pblank_d, dblank_q, dblank_d;
    logic                  pflag_q, pflag_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   dig_q, dig_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick, wrap;
    logic [3:0]            cur_code;
    logic [6:0]            seg_lit;
    logic [N_DIGITS-1:0]   dig_lit;

    // Internal glyphs are active-high, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the conditionals so no latch is inferred.
        tick     = (cnt_q == CNT_MAX);
        wrap     = tick && (idx_q == IDX_MAX);
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        pcodes_d = pcodes_q;
        pblank_d = pblank_q;
        pflag_d  = pflag_q;
        dcodes_d = dcodes_q;
        dblank_d = dblank_q;

        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        if (wrap && pflag_q) begin
            dcodes_d = pcodes_q;
            dblank_d = pblank_q;
            pflag_d  = 1'b0;
        end
        // A load in the wrap cycle lands in pending only and waits for the next wrap.
        if (load) begin
            pcodes_d = codes;
            pblank_d = blank;
            pflag_d  = 1'b1;
        end
        frame_done_d = wrap;
    end

    always_comb begin
        cur_code = dcodes_q[4*int'(idx_q) +: 4];
        seg_lit  = '0;
        dig_lit  = '0;
        if (!dblank_q[int'(idx_q)]) begin
            seg_lit = glyph(cur_code);
            dig_lit = N_DIGITS'(1) << idx_q;
        end
        seg_d = ACTIVE_LOW ? ~seg_lit : seg_lit;
        dig_d = ACTIVE_LOW ? ~dig_lit : dig_lit;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pcodes_q     <= '0;
            pblank_q     <= '1;
            pflag_q      <= 1'b0;
            dcodes_q     <= '0;
            dblank_q     <= '1;
            seg_q        <= {7{ACTIVE_LOW}};
            dig_q        <= {N_DIGITS{ACTIVE_LOW}};
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pcodes_q     <= pcodes_d;
            pblank_q     <= pblank_d;
            pflag_q      <= pflag_d;
            dcodes_q     <= dcodes_d;
            dblank_q     <= dblank_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule
